// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port RAM between an instruction port and a
// data port. Data normally wins, but after MAXD back-to-back data grants a
// waiting instruction fetch is served first. Every access is bounded by a
// TIMEOUT-cycle watchdog that aborts it with a 32'hDEADBEEF result and an err pulse.
module mem_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int MAXD    = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        err
);

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int DW = (MAXD > 0) ? $clog2(MAXD + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [DW-1:0] DCNT_MAX  = DW'(MAXD);
    localparam logic [31:0]   ABORT_VAL = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          ram_ren_q, ram_ren_d;
    logic          ram_wen_q, ram_wen_d;
    logic [31:0]   ramaddr_q, ramaddr_d;
    logic [31:0]   ramstore_q, ramstore_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;

    logic in_iacc;
    logic in_dacc;
    logic in_access;
    logic d_req;
    logic pick_d;
    logic timeout;
    logic finish;

    // Decode the current access and decide whether it ends this cycle.
    always_comb begin
        in_iacc   = (state_q == IACC);
        in_dacc   = (state_q == DACC);
        in_access = in_iacc | in_dacc;
        d_req     = dREN | dWEN;
        pick_d    = d_req & ~(iREN & (dcnt_q == DCNT_MAX));
        timeout   = in_access & ~ramready & (wcnt_q == WAIT_LAST);
        finish    = in_access & (ramready | timeout);
    end

    // Next-state logic: grant from IDLE, hold the command until ready or timeout.
    always_comb begin
        state_d    = state_q;
        ram_ren_d  = ram_ren_q;
        ram_wen_d  = ram_wen_q;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;
        dcnt_d     = dcnt_q;
        wcnt_d     = wcnt_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d    = DACC;
                    ram_wen_d  = dWEN;
                    ram_ren_d  = ~dWEN;
                    ramaddr_d  = daddr;
                    ramstore_d = dstore;
                    wcnt_d     = '0;
                    err_d      = dREN & dWEN;
                    if (dcnt_q != DCNT_MAX) begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end else if (iREN) begin
                    state_d    = IACC;
                    ram_ren_d  = 1'b1;
                    ram_wen_d  = 1'b0;
                    ramaddr_d  = iaddr;
                    ramstore_d = '0;
                    wcnt_d     = '0;
                    dcnt_d     = '0;
                end
            end
            IACC, DACC: begin
                if (finish) begin
                    state_d    = IDLE;
                    ram_ren_d  = 1'b0;
                    ram_wen_d  = 1'b0;
                    ramaddr_d  = '0;
                    ramstore_d = '0;
                    wcnt_d     = '0;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                ram_ren_d  = 1'b0;
                ram_wen_d  = 1'b0;
                ramaddr_d  = '0;
                ramstore_d = '0;
                wcnt_d     = '0;
            end
        endcase
    end

    // State and RAM command registers; reset abandons any access in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            ram_ren_q  <= 1'b0;
            ram_wen_q  <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
            dcnt_q     <= '0;
            wcnt_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_ren_q  <= ram_ren_d;
            ram_wen_q  <= ram_wen_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
            dcnt_q     <= dcnt_d;
            wcnt_q     <= wcnt_d;
            err_q      <= err_d;
        end
    end

    // Requester handshake: results are visible only in the completion cycle.
    always_comb begin
        iwait = iREN & ~(in_iacc & (ramready | timeout));
        dwait = d_req & ~(in_dacc & (ramready | timeout));
        iload = '0;
        dload = '0;
        if (in_iacc) begin
            if (ramready) begin
                iload = ramload;
            end else if (timeout) begin
                iload = ABORT_VAL;
            end
        end
        if (in_dacc) begin
            if (ramready) begin
                dload = ram_wen_q ? 32'h0 : ramload;
            end else if (timeout) begin
                dload = ABORT_VAL;
            end
        end
        err = err_q | timeout;
    end

    assign ramREN   = ram_ren_q;
    assign ramWEN   = ram_wen_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;

endmodule
